// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, handshakes with instruction memory,
// samples BTB/branch-predictor results and presents one buffered instruction
// to the decode register.
// Optional build macro: FETCH_PERF_EN adds consumption/redirect counters.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'('h8000_0000)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_fetch,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_btb_hit,
    input  logic                   i_bp_taken,
    input  logic [1:0]             i_btb_way,
    input  logic [ADDR_WIDTH-1:0]  i_btb_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
`ifdef FETCH_PERF_EN
    output logic [31:0]            o_perf_fetched,
    output logic [31:0]            o_perf_redirects,
`endif
    output logic                   o_instr_valid,
    output logic                   o_log_trace,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred,
    output logic                   o_branch_pred_taken,
    output logic [1:0]             o_btb_way
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   req_d;
    logic                   valid_d;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic [ADDR_WIDTH-1:0]  bpc_d, bpc4_d, tpred_d;
    logic                   ptaken_d;
    logic [1:0]             way_d;
    logic                   clear_buf;
    logic                   taken;
    logic                   consume_c;
    logic [ADDR_WIDTH-1:0]  redirect_aligned;
    logic [ADDR_WIDTH-1:0]  addr_plus4;
    logic                   unused_redirect_lsbs;

    assign taken                = i_btb_hit & i_bp_taken;
    assign redirect_aligned     = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign addr_plus4           = o_imem_addr + ADDR_WIDTH'(4);
    assign consume_c            = (state_q == HOLD) & ~i_stall_fetch & ~i_redirect;
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
    assign o_log_trace          = o_instr_valid;

    // Next-state, next-PC and output-buffer logic; redirect outranks stall and ack.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = o_imem_addr;
        valid_d   = o_instr_valid;
        instr_d   = o_instr;
        bpc_d     = o_pc;
        bpc4_d    = o_pc_plus4;
        tpred_d   = o_pc_target_addr_pred;
        ptaken_d  = o_branch_pred_taken;
        way_d     = o_btb_way;
        clear_buf = 1'b0;

        if (i_redirect) begin
            clear_buf = 1'b1;
            pc_d      = redirect_aligned;
            case (state_q)
                FETCH: begin
                    if (i_imem_ack) begin
                        addr_d  = redirect_aligned;
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                HOLD: begin
                    addr_d  = redirect_aligned;
                    state_d = FETCH;
                end
                DRAIN:   state_d = DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (i_imem_ack) begin
                        valid_d  = 1'b1;
                        instr_d  = i_imem_rdata;
                        bpc_d    = o_imem_addr;
                        bpc4_d   = addr_plus4;
                        ptaken_d = taken;
                        way_d    = taken ? i_btb_way : 2'b00;
                        tpred_d  = taken ? i_btb_target : '0;
                        pc_d     = taken ? i_btb_target : addr_plus4;
                        addr_d   = taken ? i_btb_target : addr_plus4;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!i_stall_fetch) begin
                        clear_buf = 1'b1;
                        state_d   = FETCH;
                    end
                end
                DRAIN: begin
                    if (i_imem_ack) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        if (clear_buf) begin
            valid_d  = 1'b0;
            instr_d  = '0;
            bpc_d    = '0;
            bpc4_d   = '0;
            tpred_d  = '0;
            ptaken_d = 1'b0;
            way_d    = 2'b00;
        end

        req_d = (state_d != HOLD);
    end

    // State, PC, request and output-buffer registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q               <= FETCH;
            pc_q                  <= RESET_PC;
            o_imem_addr           <= RESET_PC;
            o_imem_req            <= 1'b1;
            o_instr_valid         <= 1'b0;
            o_instr               <= '0;
            o_pc                  <= '0;
            o_pc_plus4            <= '0;
            o_pc_target_addr_pred <= '0;
            o_branch_pred_taken   <= 1'b0;
            o_btb_way             <= 2'b00;
        end else begin
            state_q               <= state_d;
            pc_q                  <= pc_d;
            o_imem_addr           <= addr_d;
            o_imem_req            <= req_d;
            o_instr_valid         <= valid_d;
            o_instr               <= instr_d;
            o_pc                  <= bpc_d;
            o_pc_plus4            <= bpc4_d;
            o_pc_target_addr_pred <= tpred_d;
            o_branch_pred_taken   <= ptaken_d;
            o_btb_way             <= way_d;
        end
    end

`ifdef FETCH_PERF_EN
    // Wrapping counters of consumed instructions and redirect cycles.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_perf_fetched   <= '0;
            o_perf_redirects <= '0;
        end else begin
            if (consume_c) o_perf_fetched <= o_perf_fetched + 32'(1);
            if (i_redirect) o_perf_redirects <= o_perf_redirects + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed vector table, hand sequences for
// wrap and mid-drain reset, then randomized traffic against a stream model.
module tb_instr_fetch_unit;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        arst;
    logic        stall, redirect, btb_hit, bp_taken, ack;
    logic [63:0] redirect_pc, btb_target;
    logic [1:0]  btb_way;
    logic [31:0] rdata;
    logic        req, valid, trace, ptaken;
    logic [63:0] addr, pc, pc4, tpred;
    logic [31:0] instr;
    logic [1:0]  pway;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_redirects;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .i_clk(clk), .i_arst(arst), .i_stall_fetch(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .i_btb_hit(btb_hit), .i_bp_taken(bp_taken),
        .i_btb_way(btb_way), .i_btb_target(btb_target), .o_imem_req(req),
        .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
`ifdef FETCH_PERF_EN
        .o_perf_fetched(perf_fetched), .o_perf_redirects(perf_redirects),
`endif
        .o_instr_valid(valid), .o_log_trace(trace), .o_instr(instr), .o_pc(pc),
        .o_pc_plus4(pc4), .o_pc_target_addr_pred(tpred),
        .o_branch_pred_taken(ptaken), .o_btb_way(pway)
    );

    typedef struct {
        logic        stall, redir;
        logic [63:0] rpc;
        logic        hit, tk;
        logic [1:0]  way;
        logic [63:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc, e_pc4;
        logic        e_pt;
        logic [1:0]  e_way;
        logic [63:0] e_tpred;
    } vec_t;

    typedef struct {
        logic        req, ack, stall, redir, hit, tk, valid, ptaken;
        logic [63:0] addr, rpc, tgt, pc;
        logic [1:0]  way;
        logic [31:0] instr;
    } snap_t;

    vec_t vecs[19];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; redirect = 0; redirect_pc = '0; btb_hit = 0; bp_taken = 0;
        btb_way = 0; btb_target = '0; ack = 0; rdata = '0;
    endtask

    task automatic chk_buf(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [63:0] epc, input logic [63:0] epc4);
        chk({tag, "_valid"}, 64'(valid), 64'(ev));
        chk({tag, "_trace"}, 64'(trace), 64'(ev));
        chk({tag, "_instr"}, 64'(instr), 64'(ei));
        chk({tag, "_pc"}, pc, epc);
        chk({tag, "_pc4"}, pc4, epc4);
    endtask

    initial begin
        snap_t       s;
        logic [63:0] exp_pc;
        logic        bt;
        int          delivered, consumed, redirects;
`ifdef FETCH_PERF_EN
        logic [31:0] pf0, pr0;
`endif

        //          stall redir rpc       hit tk way tgt        ack rdata          | req addr       valid instr          pc         pc4        pt way tpred
        vecs[0]  = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B,         0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[1]  = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B,         0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[2]  = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     1, 32'h13,         0, B+4,       1, 32'h13,         B,         B+4,       0, 0, 64'h0};
        vecs[3]  = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          0, B+4,       1, 32'h13,         B,         B+4,       0, 0, 64'h0};
        vecs[4]  = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          0, B+4,       1, 32'h13,         B,         B+4,       0, 0, 64'h0};
        vecs[5]  = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          0, B+4,       1, 32'h13,         B,         B+4,       0, 0, 64'h0};
        vecs[6]  = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B+4,       0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[7]  = '{1, 0, 64'h0,     1, 1, 2, B+'h100,   1, 32'hAAAA_0001,  0, B+'h100,   1, 32'hAAAA_0001,  B+4,       B+8,       1, 2, B+'h100};
        vecs[8]  = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B+'h100,   0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[9]  = '{1, 0, 64'h0,     1, 0, 3, B+'h500,   1, 32'hBBBB_0002,  0, B+'h104,   1, 32'hBBBB_0002,  B+'h100,   B+'h104,   0, 0, 64'h0};
        vecs[10] = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B+'h104,   0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[11] = '{0, 1, B+8,       0, 0, 0, 64'h0,     1, 32'hEEEE_0000,  1, B+8,       0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[12] = '{0, 1, B+'h200,   0, 0, 0, 64'h0,     0, 32'h0,          1, B+8,       0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[13] = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B+8,       0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[14] = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     1, 32'hDEAD_0000,  1, B+'h200,   0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[15] = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     1, 32'hCCCC_0003,  0, B+'h204,   1, 32'hCCCC_0003,  B+'h200,   B+'h204,   0, 0, 64'h0};
        vecs[16] = '{1, 1, B+'h203,   0, 0, 0, 64'h0,     0, 32'h0,          1, B+'h200,   0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};
        vecs[17] = '{1, 0, 64'h0,     0, 0, 0, 64'h0,     1, 32'hDDDD_0004,  0, B+'h204,   1, 32'hDDDD_0004,  B+'h200,   B+'h204,   0, 0, 64'h0};
        vecs[18] = '{0, 0, 64'h0,     0, 0, 0, 64'h0,     0, 32'h0,          1, B+'h204,   0, 32'h0,          64'h0,     64'h0,     0, 0, 64'h0};

        // Reset state
        idle();
        arst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(req), 64'(1));
        chk("rst_addr", addr, B);
        chk_buf("rst", 1'b0, 32'h0, 64'h0, 64'h0);
        chk("rst_ptaken", 64'(ptaken), 64'(0));
        arst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            btb_hit = vecs[i].hit; bp_taken = vecs[i].tk; btb_way = vecs[i].way;
            btb_target = vecs[i].tgt; ack = vecs[i].ack; rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 64'(req), 64'(vecs[i].e_req));
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
            chk_buf($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4);
            chk($sformatf("vec%0d_ptaken", i), 64'(ptaken), 64'(vecs[i].e_pt));
            chk($sformatf("vec%0d_way", i), 64'(pway), 64'(vecs[i].e_way));
            chk($sformatf("vec%0d_tpred", i), tpred, vecs[i].e_tpred);
        end

        // Address wrap at the top of the address space
        idle(); redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; ack = 1; rdata = 32'h1;
        @(negedge clk);
        chk("wrap_redir_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(); ack = 1; rdata = 32'h63; stall = 1;
        @(negedge clk);
        chk_buf("wrap", 1'b1, 32'h63, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        chk("wrap_next_addr", addr, 64'h0);
        idle();
        @(negedge clk);
        chk("wrap_consume_req", 64'(req), 64'(1));
        chk("wrap_consume_addr", addr, 64'h0);

        // Asynchronous reset while draining
        idle(); redirect = 1; redirect_pc = B + 64'h400;
        @(negedge clk);
        chk("drain_addr_hold", addr, 64'h0);
        idle();
        #2 arst = 1'b1;
        #1;
        chk("midrst_addr", addr, B);
        chk("midrst_req", 64'(req), 64'(1));
        chk("midrst_valid", 64'(valid), 64'(0));
        @(negedge clk);
        arst = 1'b0;
        ack = 1; rdata = 32'h13; stall = 1;
        @(negedge clk);
        chk_buf("postrst", 1'b1, 32'h13, B, B + 64'h4);
        idle();
        @(negedge clk);

        // Randomized traffic against an instruction-stream model
        exp_pc = '0; delivered = 0; consumed = 0; redirects = 0; s = '{default: '0};
`ifdef FETCH_PERF_EN
        pf0 = perf_fetched; pr0 = perf_redirects;
`endif
        for (int n = 0; n < 4000; n++) begin
            if (n > 0) begin
                if (s.redir) begin
                    exp_pc = {s.rpc[63:2], 2'b00};
                    chk("rnd_redir_valid", 64'(valid), 64'(0));
                    chk("rnd_redir_pc", pc, 64'h0);
                    chk("rnd_redir_instr", 64'(instr), 64'h0);
                    chk("rnd_redir_ptaken", 64'(ptaken), 64'(0));
                end else if (s.valid && s.stall) begin
                    chk("rnd_stall_valid", 64'(valid), 64'(1));
                    chk("rnd_stall_pc", pc, s.pc);
                    chk("rnd_stall_instr", 64'(instr), 64'(s.instr));
                    chk("rnd_stall_req", 64'(req), 64'(0));
                end else if (s.valid) begin
                    chk("rnd_consume_valid", 64'(valid), 64'(0));
                    chk("rnd_consume_req", 64'(req), 64'(1));
                end
                if (valid && !s.valid) begin
                    bt = s.hit & s.tk;
                    chk("rnd_new_after_ack", 64'(s.ack), 64'(1));
                    chk("rnd_new_pc", pc, exp_pc);
                    chk("rnd_new_instr", 64'(instr), 64'(mem_word(pc)));
                    chk("rnd_new_pc4", pc4, pc + 64'h4);
                    chk("rnd_new_ptaken", 64'(ptaken), 64'(bt));
                    chk("rnd_new_way", 64'(pway), bt ? 64'(s.way) : 64'h0);
                    chk("rnd_new_tpred", tpred, bt ? s.tgt : 64'h0);
                    exp_pc = bt ? s.tgt : pc + 64'h4;
                    delivered++;
                end
                if (s.req && !s.ack) chk("rnd_addr_stable", addr, s.addr);
            end

            stall    = ($urandom_range(1) == 1);
            redirect = (n == 0) || ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            else redirect_pc = B | 64'($urandom & 32'hFFFF);
            btb_hit    = ($urandom_range(2) == 0);
            bp_taken   = ($urandom_range(1) == 1);
            btb_way    = 2'($urandom_range(3));
            btb_target = B | 64'($urandom & 32'hFFFC);
            ack        = req && ($urandom_range(1) == 1);
            rdata      = ack ? mem_word(addr) : $urandom;

            if (redirect) redirects++;
            else if (valid && !stall) consumed++;

            s.req = req; s.ack = ack; s.stall = stall; s.redir = redirect;
            s.hit = btb_hit; s.tk = bp_taken; s.valid = valid; s.ptaken = ptaken;
            s.addr = addr; s.rpc = redirect_pc; s.tgt = btb_target; s.pc = pc;
            s.way = btb_way; s.instr = instr;
            @(negedge clk);
        end
        chk("rnd_delivered_enough", 64'(delivered > 100), 64'(1));
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched - pf0), 64'(32'(consumed)));
        chk("perf_redirects", 64'(perf_redirects - pr0), 64'(32'(redirects)));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch unit producing the instruction stream consumed by the fetch/decode pipeline register. It owns the fetch PC, runs a request/acknowledge handshake with instruction memory, and samples BTB/branch-predictor results. It presents one buffered instruction with its PC, PC+4, prediction fields and trace flag, exactly as the decode register expects, and honours decode stall and back-end redirects.

## Interface
- ADDR_WIDTH, 64, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 'h8000_0000, first fetch address after reset
- i_clk  in  1  clock, all state on rising edge
- i_arst  in  1  asynchronous active-high reset
- i_stall_fetch  in  1  decode register not accepting (hazard stall)
- i_redirect  in  1  back-end redirect (mispredict/jump resolve)
- i_redirect_pc  in  ADDR_WIDTH  redirect target
- i_btb_hit / i_bp_taken  in  1 each  BTB hit / direction prediction for o_imem_addr
- i_btb_way  in  2  BTB way of the hit
- i_btb_target  in  ADDR_WIDTH  predicted target
- o_imem_req  out  1  memory request
- o_imem_addr  out  ADDR_WIDTH  request address; also BTB lookup address
- i_imem_ack  in  1  response valid, completes the request
- i_imem_rdata  in  INSTR_WIDTH  instruction, valid with ack
- o_instr_valid, o_log_trace  out  1 each  buffer holds a real instruction
- o_instr  out  INSTR_WIDTH;  o_pc, o_pc_plus4, o_pc_target_addr_pred  out  ADDR_WIDTH
- o_branch_pred_taken  out  1;  o_btb_way  out  2

## Operation
- State registers: pc_q (next fetch PC), o_imem_addr (registered), one-entry output buffer, FSM {FETCH, HOLD, DRAIN}.
- Reset: state FETCH, pc_q = o_imem_addr = RESET_PC, all buffer outputs 0. o_imem_req = (state != HOLD), so it reads 1 during reset; memory ignores requests while i_arst is high.
- Memory rule: while o_imem_req = 1, o_imem_addr is stable until the ack cycle. Ack may arrive in the same cycle as the request or any number of cycles later.
- FETCH, ack, no redirect:
  - Buffer loads instr = rdata, pc = o_imem_addr, pc_plus4 = o_imem_addr + 4.
  - taken = i_btb_hit & i_bp_taken. o_branch_pred_taken = taken; o_btb_way and o_pc_target_addr_pred take the BTB values if taken, else 0.
  - o_instr_valid = o_log_trace = 1.
  - pc_q, o_imem_addr <= taken ? i_btb_target : o_imem_addr + 4.
  - Go to HOLD.
- HOLD: buffer stable while i_stall_fetch = 1. If i_stall_fetch = 0, the edge counts as consumption: buffer cleared to 0, go to FETCH.
- Redirect has top priority over stall and ack. All buffer outputs go to 0, and pc_q <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - FETCH with no ack that cycle -> DRAIN; o_imem_addr holds.
  - FETCH with ack that cycle -> data dropped, o_imem_addr <= aligned target, go to FETCH.
  - HOLD -> FETCH; o_imem_addr <= aligned target.
  - DRAIN -> update pc_q, stay in DRAIN.
- DRAIN: request stays on the old address. On ack, data is discarded, o_imem_addr <= pc_q, go to FETCH.
- Arithmetic: +4 is modulo 2^ADDR_WIDTH (wrap, no flag).
- Reset asserted mid-request or mid-drain: state returns to reset values immediately. The outstanding response is not tracked.

## Timing
- Ack at cycle N -> o_instr_valid = 1 from cycle N+1.
- Consume at edge ending cycle M -> o_instr_valid = 0 and o_imem_req = 1 in cycle M+1 with the next address.
- Peak throughput is 1 instruction per 2 cycles with zero-latency memory.
- Redirect in cycle R -> outputs cleared in R+1. A request to the new target is issued in R+1, or in the cycle after the draining ack.

## Configuration
- FETCH_PERF_EN defined: adds two 32-bit wrapping counters, reset to 0.
  - o_perf_fetched (out, 32) increments on each consumption.
  - o_perf_redirects (out, 32) increments on each i_redirect cycle.
- FETCH_PERF_EN undefined: the counters and both ports are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, ack 2 cycles later with 0x00000013 -> o_instr = 0x13, o_pc = 0x8000_0000, o_pc_plus4 = 0x8000_0004, valid = trace = 1. After consume, request to 0x8000_0004.
- Instruction held with i_stall_fetch = 1 for 3 cycles -> all outputs stable, o_imem_req = 0. Stall drop -> valid = 0 next cycle.
- BTB hit + taken, target 0x8000_0100, way 2 -> pred_taken = 1, btb_way = 2, target_pred = 0x8000_0100, next address 0x8000_0100. Miss -> prediction fields 0, next address PC+4.
- Redirect to 0x8000_0200 while request to 0x8000_0008 is pending -> address stays 0x8000_0008 until ack, data dropped (valid stays 0), then request to 0x8000_0200.
- Redirect during HOLD with stall high -> outputs all 0 next cycle, request to the aligned target. Redirect to 0x8000_0203 -> fetch from 0x8000_0200.
- Fetch at 0xFFFF_FFFF_FFFF_FFFC, no prediction -> o_pc_plus4 = 0, next request address 0.
